// File: rtl/obc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obc_pkg
//  Description : Shared definitions for the offset-binary-coding shift
//                accumulator: default widths and the controller state enum.
//  Revision    : 1.0 - initial release
// ============================================================================
package obc_pkg;

    // LUT word, accumulator and result width
    localparam int DW_DEFAULT    = 32;
    // Number of bit-planes (beats) per output sample
    localparam int NBITS_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : obc_pkg
`default_nettype wire

// File: rtl/obc_shift_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : obc_shift_acc_if
//  Description : Request / LUT-beat / result bus of the OBC shift accumulator.
//                master : the client (issues start, streams LUT beats,
//                         consumes the result)
//                slave  : the accumulator
//  Signals     : start, offset           - begin a sample with this constant
//                lut_valid, lut_data     - one bit-plane partial sum, MSB first
//                in_ready                - accumulator takes a beat this cycle
//                out_valid, out_ready    - result handshake
//                result                  - accumulated sample
//                busy                    - accumulator is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
interface obc_shift_acc_if
    import obc_pkg::*;
#(
    parameter int DW = DW_DEFAULT
);
    logic                 start;
    logic signed [DW-1:0] offset;
    logic                 lut_valid;
    logic signed [DW-1:0] lut_data;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] result;
    logic                 busy;

    modport master (
        output start,
        output offset,
        output lut_valid,
        output lut_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  start,
        input  offset,
        input  lut_valid,
        input  lut_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );

endinterface : obc_shift_acc_if
`default_nettype wire

// File: rtl/obc_acc_step.sv
`default_nettype none
// ============================================================================
//  Module      : obc_acc_step
//  Description : One combinational accumulation step of the OBC shift
//                accumulator. The MSB bit-plane carries negative weight, so
//                the first beat starts the accumulator at -d; every later
//                beat doubles the running sum and adds d. All arithmetic wraps
//                modulo 2^DW.
//  Ports       : first - current beat is the MSB plane
//                acc   - running accumulator
//                d     - LUT partial sum for this plane
//                y     - next accumulator value
//  Revision    : 1.0 - initial release
// ============================================================================
module obc_acc_step #(
    parameter int DW = 32
) (
    input  wire logic          first,
    input  wire logic [DW-1:0] acc,
    input  wire logic [DW-1:0] d,
    output logic      [DW-1:0] y
);

    logic [DW-1:0] w_neg;
    logic [DW-1:0] w_shift_add;

    assign w_neg       = '0 - d;
    assign w_shift_add = {acc[DW-2:0], 1'b0} + d;
    assign y           = first ? w_neg : w_shift_add;

endmodule : obc_acc_step
`default_nettype wire

// File: rtl/obc_shift_acc.sv
`default_nettype none
// ============================================================================
//  Module      : obc_shift_acc
//  Description : Offset-binary-coding shift accumulator. After a start the
//                block accepts NBITS LUT partial sums (MSB plane first),
//                forms  -L[N-1]*2^(N-1) + sum_{j<N-1} L[j]*2^j + offset
//                with two's complement wrap, and holds the result under a
//                valid/ready handshake until it is taken.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - obc_shift_acc_if.slave (start/offset, LUT beats,
//                       result handshake, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module obc_shift_acc
    import obc_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int NBITS = NBITS_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           rst,
    obc_shift_acc_if.slave      bus
);

    localparam int            CW     = $clog2(NBITS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(NBITS - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_offset;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_result;
    logic          r_out_valid;

    logic          w_in_ready;
    logic          w_busy;
    logic          w_beat;
    logic          w_first;
    logic          w_last;
    logic [DW-1:0] w_step;

    // ------------------------------------------------------------------------
    // Datapath step
    // ------------------------------------------------------------------------
    obc_acc_step #(
        .DW (DW)
    ) u_step (
        .first (w_first),
        .acc   (r_acc),
        .d     (bus.lut_data),
        .y     (w_step)
    );

    assign w_beat  = bus.lut_valid & w_in_ready;
    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == C_LAST);

    // ------------------------------------------------------------------------
    // Next state and decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = ACC;
                end
            end
            ACC: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (w_beat && w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_busy = 1'b1;
                // A start coinciding with the handshake is dropped: the FSM
                // only looks at start while it is in IDLE.
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_offset    <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_offset <= bus.offset;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                ACC: begin
                    // Stall cycles (lut_valid low) leave acc and count alone
                    if (w_beat) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + C_ONE;
                        if (w_last) begin
                            r_result    <= w_step + r_offset;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

endmodule : obc_shift_acc
`default_nettype wire
